// File: rtl/rs_pulse_gen.sv
// -----------------------------------------------------------------------------
// rs_pulse_gen
//
// Purpose
//   Front-end for the RS latch. Takes two raw, bouncy, asynchronous push
//   buttons and turns each clean press into a single clock-aligned pulse on a
//   (set) or b (reset). a and b are never high in the same cycle, and every
//   pulse is followed by a forced idle gap.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced level flips (>=1)
//   PULSE_LEN        cycles each a/b pulse stays high (>=1)
//   GAP_LEN          idle cycles forced after every pulse (>=1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_set    in   raw set button (asynchronous, may bounce)
//   btn_reset  in   raw reset button (asynchronous, may bounce)
//   a          out  registered set pulse to the latch
//   b          out  registered reset pulse to the latch
//   busy       out  registered, high whenever the pulse FSM is not idle
//
// Build option
//   RS_PENDING_EN  when defined, a request that collides with an active
//                  pulse (or loses simultaneous arbitration) is held in a
//                  one-entry pending register and issued after the gap.
//                  When undefined, such requests are dropped.
// -----------------------------------------------------------------------------
module rs_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2,
    parameter int GAP_LEN         = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic a,
    output logic b,
    output logic busy
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_LEN - 1);

    // Channel index 0 carries the set button, index 1 the reset button.
    localparam int CH_SET = 0;
    localparam int CH_RST = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_A = 2'd1,
        PULSE_B = 2'd2,
        GAP     = 2'd3
    } state_t;

    // One debounce step: returns {next_level, next_count}. The counter only
    // runs while the synchronized input disagrees with the debounced level;
    // any agreeing cycle restarts it, so a bounce never accumulates.
    function automatic logic [DB_W:0] debounce_step(
        input logic            sync_lvl,
        input logic            deb_lvl,
        input logic [DB_W-1:0] cnt
    );
        logic            lvl_n;
        logic [DB_W-1:0] cnt_n;
        lvl_n = deb_lvl;
        cnt_n = '0;
        if (sync_lvl != deb_lvl) begin
            if (cnt == DB_LAST) begin
                lvl_n = sync_lvl;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
        return {lvl_n, cnt_n};
    endfunction

    logic [1:0]           sync1_p0;
    logic [1:0]           sync2_p1;
    logic [1:0]           deb_p2;
    logic [1:0][DB_W-1:0] db_cnt_p2;
    logic [1:0]           deb_nxt;
    logic [1:0][DB_W-1:0] db_cnt_nxt;
    logic [1:0]           deb_q_p3;
    logic [1:0]           req_p3;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic             req_set;
    logic             req_rst;
    logic             conf_set;
    logic             conf_rst;
    logic             a_nxt;
    logic             b_nxt;
    logic             busy_nxt;

`ifdef RS_PENDING_EN
    logic pend_vld;
    logic pend_b;
    logic pend_vld_nxt;
    logic pend_b_nxt;
    logic pm_vld;
    logic pm_b;
`endif

    // ---- Stage p0/p1: two-flop synchronizers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
        end else begin
            sync1_p0 <= {btn_reset, btn_set};
            sync2_p1 <= sync1_p0;
        end
    end

    // ---- Stage p2: debounce ----
    always_comb begin
        deb_nxt    = deb_p2;
        db_cnt_nxt = db_cnt_p2;
        for (int i = 0; i < 2; i++) begin
            {deb_nxt[i], db_cnt_nxt[i]} = debounce_step(sync2_p1[i], deb_p2[i], db_cnt_p2[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_p2    <= '0;
            db_cnt_p2 <= '0;
        end else begin
            deb_p2    <= deb_nxt;
            db_cnt_p2 <= db_cnt_nxt;
        end
    end

    // ---- Stage p3: rising-edge detect, one-cycle requests ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q_p3 <= '0;
            req_p3   <= '0;
        end else begin
            deb_q_p3 <= deb_p2;
            req_p3   <= deb_p2 & ~deb_q_p3;
        end
    end

    assign req_set = req_p3[CH_SET];
    assign req_rst = req_p3[CH_RST];

    // ---- Pulse FSM: state register ----
    // a/b/busy are registered from the next-state decode so they change
    // only on clock edges and track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
`ifdef RS_PENDING_EN
            pend_vld <= 1'b0;
            pend_b   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            busy  <= busy_nxt;
`ifdef RS_PENDING_EN
            pend_vld <= pend_vld_nxt;
            pend_b   <= pend_b_nxt;
`endif
        end
    end

    // ---- Pulse FSM: next-state logic ----
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        conf_set  = 1'b0;
        conf_rst  = 1'b0;
`ifdef RS_PENDING_EN
        pend_vld_nxt = pend_vld;
        pend_b_nxt   = pend_b;
        pm_vld       = pend_vld;
        pm_b         = pend_b;
`endif

        // Classify incoming requests. A request matching the pulse being
        // driven is redundant and silently dropped; anything else that
        // cannot start right now is a conflict.
        case (state)
            IDLE: begin
                conf_set = req_set & req_rst;
            end
            PULSE_A: begin
                conf_rst = req_rst;
            end
            PULSE_B: begin
                conf_set = req_set;
            end
            GAP: begin
                conf_set = req_set;
                conf_rst = req_rst;
            end
            default: begin
                conf_set = 1'b0;
                conf_rst = 1'b0;
            end
        endcase

`ifdef RS_PENDING_EN
        // Merge this cycle's conflict into the pending slot. A newer reset
        // always replaces the slot; a newer set never displaces a reset.
        if (conf_rst) begin
            pm_vld = 1'b1;
            pm_b   = 1'b1;
        end else if (conf_set && !(pend_vld && pend_b)) begin
            pm_vld = 1'b1;
            pm_b   = 1'b0;
        end
        pend_vld_nxt = pm_vld;
        pend_b_nxt   = pm_b;
`endif

        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (req_rst) begin
                    state_nxt = PULSE_B;
                end else if (req_set) begin
                    state_nxt = PULSE_A;
                end
            end
            PULSE_A, PULSE_B: begin
                if (tmr == PULSE_LAST) begin
                    state_nxt = GAP;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            GAP: begin
                if (tmr == GAP_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = IDLE;
`ifdef RS_PENDING_EN
                    if (pm_vld) begin
                        state_nxt    = pm_b ? PULSE_B : PULSE_A;
                        pend_vld_nxt = 1'b0;
                        pend_b_nxt   = 1'b0;
                    end
`endif
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

`ifndef RS_PENDING_EN
    // Without a pending slot, conflicts are simply discarded.
    logic unused_conf;
    assign unused_conf = conf_set ^ conf_rst;
`endif

    // ---- Pulse FSM: output decode ----
    always_comb begin
        a_nxt    = (state_nxt == PULSE_A);
        b_nxt    = (state_nxt == PULSE_B);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_rs_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_rs_pulse_gen
//
// Directed bench for rs_pulse_gen with default parameters
// (DEBOUNCE_CYCLES=4, PULSE_LEN=2, GAP_LEN=1). Relative edge r=0 is the first
// clock edge that samples a newly applied button level; a clean press then
// shows a pulse after edges r=7 and r=8.
// -----------------------------------------------------------------------------
module tb_rs_pulse_gen;

    localparam int PULSE_LEN = 2;
    localparam int GAP_LEN   = 1;

    logic clk;
    logic rst_n;
    logic btn_set;
    logic btn_reset;
    logic a;
    logic b;
    logic busy;

    int checks = 0;
    int errors = 0;

    rs_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_LEN      (PULSE_LEN),
        .GAP_LEN        (GAP_LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_set  (btn_set),
        .btn_reset(btn_reset),
        .a        (a),
        .b        (b),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Buttons already low: wait for the debounced levels to settle, and
    // confirm the falling edges produce nothing.
    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_a_r%0d", tag, i), a, 1'b0);
            chk($sformatf("%s_b_r%0d", tag, i), b, 1'b0);
        end
    endtask

    logic exp_a;
    logic exp_b;
    logic tgt_s;
    logic tgt_r;
    logic a_prev;
    logic b_prev;
    int   a_run;
    int   b_run;
    int   idle_run;
    int   pulses;

    initial begin
        rst_n     = 1'b0;
        btn_set   = 1'b0;
        btn_reset = 1'b0;

        // Reset state
        tick();
        tick();
        tick();
        chk("rst_a", a, 1'b0);
        chk("rst_b", b, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle_chk("post_rst", 5);

        // Clean press held for 20 cycles: one pulse on a at r=7..8
        btn_set = 1'b1;
        for (int r = 0; r < 20; r++) begin
            tick();
            chk($sformatf("press_a_r%0d", r), a, (r == 7 || r == 8) ? 1'b1 : 1'b0);
            chk($sformatf("press_b_r%0d", r), b, 1'b0);
            chk($sformatf("press_busy_r%0d", r), busy, (r >= 7 && r <= 9) ? 1'b1 : 1'b0);
        end
        btn_set = 1'b0;
        idle_chk("press_rel", 12);

        // Bouncing reset button: 1,0,1,0 then held, stable from r=4
        for (int r = 0; r < 20; r++) begin
            btn_reset = (r >= 4) ? 1'b1 : ((r % 2 == 0) ? 1'b1 : 1'b0);
            tick();
            chk($sformatf("bounce_b_r%0d", r), b, (r == 11 || r == 12) ? 1'b1 : 1'b0);
            chk($sformatf("bounce_a_r%0d", r), a, 1'b0);
        end
        btn_reset = 1'b0;
        idle_chk("bounce_rel", 12);

        // Simultaneous presses: reset wins, set follows only with pending
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        for (int r = 0; r < 20; r++) begin
            tick();
            exp_b = (r == 7 || r == 8) ? 1'b1 : 1'b0;
`ifdef RS_PENDING_EN
            exp_a = (r == 10 || r == 11) ? 1'b1 : 1'b0;
`else
            exp_a = 1'b0;
`endif
            chk($sformatf("simul_b_r%0d", r), b, exp_b);
            chk($sformatf("simul_a_r%0d", r), a, exp_a);
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        idle_chk("simul_rel", 12);

        // Set request landing while b is pulsing
        for (int r = 0; r < 20; r++) begin
            btn_reset = 1'b1;
            if (r >= 1) btn_set = 1'b1;
            tick();
            exp_b = (r == 7 || r == 8) ? 1'b1 : 1'b0;
`ifdef RS_PENDING_EN
            exp_a = (r == 10 || r == 11) ? 1'b1 : 1'b0;
`else
            exp_a = 1'b0;
`endif
            chk($sformatf("busy_conf_b_r%0d", r), b, exp_b);
            chk($sformatf("busy_conf_a_r%0d", r), a, exp_a);
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        idle_chk("busy_conf_rel", 12);

        // Asynchronous reset in the middle of an a pulse
        btn_set = 1'b1;
        for (int r = 0; r < 8; r++) begin
            tick();
        end
        chk("mid_pulse_a", a, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a", a, 1'b0);
        chk("async_rst_b", b, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        btn_set = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        idle_chk("after_async_rst", 15);

        // Random bouncy stimulus on both buttons
        tgt_s    = 1'b0;
        tgt_r    = 1'b0;
        a_prev   = 1'b0;
        b_prev   = 1'b0;
        a_run    = 0;
        b_run    = 0;
        idle_run = 1000;
        pulses   = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 29) == 0) tgt_s = ~tgt_s;
            if ($urandom_range(0, 29) == 0) tgt_r = ~tgt_r;
            btn_set   = tgt_s ^ (($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
            btn_reset = tgt_r ^ (($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
            tick();
            chk("rand_a_and_b", a & b, 1'b0);
            if ((a && !a_prev) || (b && !b_prev)) begin
                chk("rand_gap", (idle_run >= GAP_LEN) ? 1'b1 : 1'b0, 1'b1);
            end
            if (a) begin
                a_run++;
            end else begin
                if (a_run != 0) begin
                    chk_int("rand_a_width", a_run, PULSE_LEN);
                    pulses++;
                end
                a_run = 0;
            end
            if (b) begin
                b_run++;
            end else begin
                if (b_run != 0) begin
                    chk_int("rand_b_width", b_run, PULSE_LEN);
                    pulses++;
                end
                b_run = 0;
            end
            if (a || b) idle_run = 0;
            else        idle_run++;
            a_prev = a;
            b_prev = b;
        end
        chk("rand_pulses_seen", (pulses > 0) ? 1'b1 : 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
